// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight and fills the IF/ID slot.
// Optional IF_MISALIGN_TRAP_EN adds if_misaligned and traps fetches from a misaligned PC.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        if_misaligned,
`endif
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] pc;
    logic        slot_free;
    logic        trap;
    logic        resp_take;

    // A request may only go out when its response is guaranteed an empty slot.
    assign slot_free = !if_valid || !stall_i;
    assign resp_take = (state == WAIT) && imem_resp_valid && !redirect_valid;

`ifdef IF_MISALIGN_TRAP_EN
    assign trap = (state == REQ) && !redirect_valid && slot_free && (pc[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REQ;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves next_state unassigned and infers a latch.
        next_state = state;
        case (state)
            REQ: begin
                if (redirect_valid) begin
                    next_state = REQ;
                end else if (trap) begin
                    next_state = HALT;
                end else if (imem_req_valid && imem_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    next_state = imem_resp_valid ? REQ : DRAIN;
                end else if (imem_resp_valid) begin
                    next_state = REQ;
                end
            end
            // The response that retires a drain may coincide with another redirect; pc still updates.
            DRAIN: begin
                if (imem_resp_valid) begin
                    next_state = REQ;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    next_state = REQ;
                end
            end
            default: next_state = REQ;
        endcase
    end

    always_comb begin
        imem_addr      = {pc[63:2], 2'b00};
        imem_req_valid = !rst && (state == REQ) && !redirect_valid && slot_free && !trap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= 64'h0;
            if_inst  <= 32'h0;
`ifdef IF_MISALIGN_TRAP_EN
            if_misaligned <= 1'b0;
`endif
        end else begin
            if (if_valid && !stall_i) begin
                if_valid <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                if_misaligned <= 1'b0;
`endif
            end
            if (redirect_valid) begin
                pc       <= redirect_pc;
                if_valid <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                if_misaligned <= 1'b0;
`endif
            end else if (resp_take) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= imem_resp_data;
                pc       <= pc + 64'd4;
            end else if (trap) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= 32'h0;
`ifdef IF_MISALIGN_TRAP_EN
                if_misaligned <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit: a transaction-level model predicts requests and slot contents.
// Build with IF_MISALIGN_TRAP_EN defined to also exercise the misaligned-PC trap.
module tb_if_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          NCYC     = 3000;
    localparam int          RST_CYC  = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_misaligned;
`endif

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
`ifdef IF_MISALIGN_TRAP_EN
        .if_misaligned   (if_misaligned),
`endif
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } slot_t;

    slot_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model: fetch PC, one in-flight fetch (possibly doomed by a redirect), halt after a trap.
    logic [63:0] model_pc;
    bit          outstanding;
    bit          drop;
    bit          halted;
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc    = RESET_PC;
        outstanding = 0;
        drop        = 0;
        halted      = 0;
        mem_pending = 0;
        mem_cnt     = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst if_valid", if_valid, 0);
        check("rst if_pc", if_pc, 0);
        check("rst if_inst", if_inst, 0);
        check("rst imem_req_valid", imem_req_valid, 0);
`ifdef IF_MISALIGN_TRAP_EN
        check("rst if_misaligned", if_misaligned, 0);
`endif
    endtask

    function automatic logic [63:0] pick_pc();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return 64'h1000;
            1:       return 64'hFFFF_FFFF_FFFF_FFFC;
            2:       return 64'hFFFF_FFFF_FFFF_FFF4;
            3:       return 64'h1002;
            4:       return 64'h2000;
            default: return {r[63:2], 2'b00};
        endcase
    endfunction

    task automatic drive(input int cyc);
        bit directed;
        directed = (cyc < 40);
        rst = (cyc == RST_CYC) || (cyc == RST_CYC + 1);
        stall_i        = directed ? 1'b0 : ($urandom_range(0, 3) == 0);
        redirect_valid = !directed && !rst && ($urandom_range(0, 11) == 0);
        redirect_pc    = pick_pc();
        imem_req_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (rst) begin
            model_reset();
        end else if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_data;
            end
        end
    endtask

    // Evaluates what the coming clock edge will do, after the monitor has judged the current slot.
    task automatic observe();
        bit slot_free;
        bit misal;
        bit can_fetch;
        bit exp_req;
        if (rst) begin
            check_reset_outputs();
            return;
        end
        slot_free = (exp_q.size() == 0) || !stall_i;
`ifdef IF_MISALIGN_TRAP_EN
        misal = (model_pc[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        can_fetch = !outstanding && !halted && !redirect_valid && slot_free;
        exp_req   = can_fetch && !misal;
        check("imem_req_valid", imem_req_valid, exp_req);
        if (exp_req) check("imem_addr", imem_addr, {model_pc[63:2], 2'b00});

        if (redirect_valid) begin
            exp_q.delete();
            model_pc = redirect_pc;
            halted   = 0;
            if (outstanding) begin
                if (imem_resp_valid) begin
                    outstanding = 0;
                    drop        = 0;
                end else begin
                    drop = 1;
                end
            end
        end else if (outstanding && imem_resp_valid) begin
            if (!drop) begin
                exp_q.push_back({model_pc, imem_resp_data, 1'b0});
                model_pc = model_pc + 64'd4;
            end
            outstanding = 0;
            drop        = 0;
        end else if (can_fetch && misal) begin
            exp_q.push_back({model_pc, 32'h0, 1'b1});
            halted = 1;
        end else if (exp_req && imem_req_valid && imem_req_ready) begin
            outstanding = 1;
            mem_pending = 1;
            mem_cnt     = $urandom_range(1, 3);
            mem_data    = $urandom;
        end
        if (imem_resp_valid) mem_pending = 0;
    endtask

    // Monitor: the slot must match the head of the expected queue; consumption pops it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (exp_q.size() == 0) begin
                check("if_valid idle", if_valid, 0);
`ifdef IF_MISALIGN_TRAP_EN
                check("if_misaligned idle", if_misaligned, 0);
`endif
            end else begin
                check("if_valid", if_valid, 1);
                check("if_pc", if_pc, exp_q[0].pc);
                check("if_inst", if_inst, exp_q[0].inst);
`ifdef IF_MISALIGN_TRAP_EN
                check("if_misaligned", if_misaligned, exp_q[0].mis);
`endif
                if (!stall_i && !redirect_valid) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst             = 1'b1;
        stall_i         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            drive(cyc);
            @(negedge clk);
            #1;
            observe();
            @(posedge clk);
            #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage: owns the 64-bit fetch PC, issues single-outstanding requests to instruction memory, and presents each fetched instruction with its PC and a valid bit to the IF/ID pipeline register. It honours the stall and flush/redirect signals that also drive IF/ID, so the IF/ID register captures `if_pc`/`if_inst`/`if_valid` on every cycle where `stall_i` is low.

## Interface
- `RESET_PC`, 64'h0, PC loaded on reset.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_i`  in  1  IF/ID stall; output slot is not consumed while high.
- `redirect_valid`  in  1  branch/jump/flush redirect; same pulse that flushes IF/ID.
- `redirect_pc`  in  64  new fetch PC, sampled when `redirect_valid` is high.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  64  fetch address, word aligned.
- `imem_resp_valid`  in  1  instruction data returned, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `if_valid`  out  1  output slot holds an instruction.
- `if_pc`  out  64  PC of the slot instruction.
- `if_inst`  out  32  slot instruction.

## Operation
- Registers: `pc`, 2-bit `state` {REQ, WAIT, DRAIN, HALT}, output slot (`if_valid`, `if_pc`, `if_inst`).
- Slot consumption: a slot is consumed in any cycle where `if_valid && !stall_i`. It then clears next cycle unless it is reloaded.
- REQ: `imem_req_valid = !redirect_valid && (!if_valid || !stall_i)`, with `imem_addr = {pc[63:2],2'b00}`. On `imem_req_valid && imem_req_ready`, go to WAIT.
- WAIT: on `imem_resp_valid`:
  - load slot ← {1, `pc`, `imem_resp_data`};
  - `pc` ← `pc + 64'd4` (mod 2^64, wraps silently);
  - go to REQ.
- Redirect (any state, highest priority):
  - `pc` ← `redirect_pc`; slot `if_valid` ← 0.
  - From WAIT without a same-cycle response: go to DRAIN.
  - From WAIT with a same-cycle response: discard the response and go to REQ.
  - From REQ or HALT: go to REQ, with no request that cycle.
- DRAIN: discard the next `imem_resp_valid` (slot and pc untouched), then go to REQ. A further redirect in DRAIN updates `pc` and stays in DRAIN.
- Slot-space rule: a request is only issued when the slot is empty or is being consumed that cycle, so a response never finds the slot occupied.
- Response while in REQ: protocol violation, ignored.

## Timing
- Reset values:
  - `pc = RESET_PC`, `state = REQ`;
  - `if_valid = 0`, `if_pc = 0`, `if_inst = 0`;
  - `imem_req_valid = 0` while `rst` is high.
- `imem_req_valid`/`imem_addr` are combinational from state, pc and inputs. Slot outputs are registered.
- Minimum latency: request accepted at cycle N, response at N+1, `if_valid` high at N+2.
- Peak throughput: one instruction per 2 cycles (REQ, WAIT).
- Redirect at cycle N (state REQ, zero-wait memory): request to `redirect_pc` at N+1, `if_valid` with that PC at N+3.
- `rst` mid-transaction: state returns to REQ. Any in-flight response after reset is ignored because the state is REQ.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined:
  - adds output `if_misaligned` (1 bit, reset 0);
  - in REQ, with no redirect, slot free and `pc[1:0] != 0`: no memory request; slot ← {1, `pc`, 32'h0}, `if_misaligned` ← 1, `pc` unchanged, go to HALT;
  - HALT issues nothing until a redirect, which also clears `if_misaligned`;
  - `if_misaligned` clears together with `if_valid` on consumption.
- Undefined: no port; `pc[1:0]` is ignored via the forced-aligned `imem_addr`, and fetch proceeds normally.

## Test plan
- Reset release, memory `ready` = 1, responses at +1 cycle, `stall_i` = 0 → addresses 0x0, 0x4, 0x8. `if_valid` is high every other cycle, with `if_pc` = 0x0/0x4/0x8 and `if_inst` equal to the memory data.
- `stall_i` high for 5 cycles while slot is full → no new `imem_req_valid`; `if_pc`/`if_inst` stable. Fetch resumes on the cycle `stall_i` drops.
- Redirect to 0x1000 while in WAIT, response 2 cycles later → that response is dropped (`if_valid` stays 0). Next request address is 0x1000, and `if_pc` = 0x1000.
- Redirect and `imem_resp_valid` in the same cycle → response discarded, `if_valid` = 0 next cycle, next request at `redirect_pc`.
- `pc` = 64'hFFFF_FFFF_FFFF_FFFC fetch → next `imem_addr` = 0x0 (wrap).
- `IF_MISALIGN_TRAP_EN`, redirect to 0x1002 → no request; `if_valid` = 1, `if_misaligned` = 1, `if_pc` = 0x1002, `if_inst` = 0. A redirect to 0x2000 clears the slot and resumes fetch at 0x2000.
